// File: rtl/io_port_bridge_if.sv
// Port bundle between the datapath/device side and io_port_bridge.
//   slave  : the bridge itself (receives strobes, drives heads/status)
//   master : whoever drives the datapath strobes and device handshake
// cpu_* : datapath OUTPUT/INPUT port side
// dev_* : external device valid/ready side
// last_out, out_count, in_count, overflow, underflow, status_clr : status
interface io_port_bridge_if #(
   parameter int BITS      = 32,
   parameter int OUT_DEPTH = 4,
   parameter int IN_DEPTH  = 4
) ();
   localparam int OCW = $clog2(OUT_DEPTH) + 1;
   localparam int ICW = $clog2(IN_DEPTH) + 1;

   logic            cpu_out_wr;
   logic [BITS-1:0] cpu_out_data;
   logic            cpu_out_full;
   logic            cpu_in_rd;
   logic [BITS-1:0] cpu_in_data;
   logic            cpu_in_empty;
   logic            dev_out_valid;
   logic [BITS-1:0] dev_out_data;
   logic            dev_out_ready;
   logic            dev_in_valid;
   logic [BITS-1:0] dev_in_data;
   logic            dev_in_ready;
   logic [BITS-1:0] last_out;
   logic [OCW-1:0]  out_count;
   logic [ICW-1:0]  in_count;
   logic            overflow;
   logic            underflow;
   logic            status_clr;

   modport slave (
      input  cpu_out_wr, cpu_out_data, cpu_in_rd, dev_out_ready,
             dev_in_valid, dev_in_data, status_clr,
      output cpu_out_full, cpu_in_data, cpu_in_empty, dev_out_valid,
             dev_out_data, dev_in_ready, last_out, out_count, in_count,
             overflow, underflow
   );

   modport master (
      output cpu_out_wr, cpu_out_data, cpu_in_rd, dev_out_ready,
             dev_in_valid, dev_in_data, status_clr,
      input  cpu_out_full, cpu_in_data, cpu_in_empty, dev_out_valid,
             dev_out_data, dev_in_ready, last_out, out_count, in_count,
             overflow, underflow
   );
endinterface

// File: rtl/io_port_bridge.sv
// Device-side end of the processor INPUT/OUTPUT port.
// Output path: datapath OUTPUTin strobes words into a show-ahead FIFO that
// drains to the device over valid/ready. Input path: device words fill a
// second show-ahead FIFO whose head feeds INPUTUnit, popped on INPUTout.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low clear of pointers, counts and flags
//   bus   : io_port_bridge_if.slave carrying all data/handshake/status
module io_port_bridge #(
   parameter int BITS      = 32,
   parameter int OUT_DEPTH = 4,
   parameter int IN_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   io_port_bridge_if.slave   bus
);
   localparam int OPW = $clog2(OUT_DEPTH);
   localparam int IPW = $clog2(IN_DEPTH);
   localparam int OCW = OPW + 1;
   localparam int ICW = IPW + 1;
   localparam logic [OCW-1:0] OUT_FULL = OCW'(OUT_DEPTH);
   localparam logic [ICW-1:0] IN_FULL  = ICW'(IN_DEPTH);

   logic [BITS-1:0] out_mem_q [OUT_DEPTH];
   logic [BITS-1:0] in_mem_q  [IN_DEPTH];

   logic [OPW-1:0]  out_wp_q, out_wp_d, out_rp_q, out_rp_d;
   logic [OCW-1:0]  out_cnt_q, out_cnt_d;
   logic [IPW-1:0]  in_wp_q, in_wp_d, in_rp_q, in_rp_d;
   logic [ICW-1:0]  in_cnt_q, in_cnt_d;
   logic [BITS-1:0] last_q, last_d;
   logic            ovf_q, ovf_d, unf_q, unf_d;

   logic out_push, out_pop, in_push, in_pop;

   always_comb begin
      out_pop  = (out_cnt_q != '0) && bus.dev_out_ready;
      // A full FIFO still accepts a write when the head leaves this cycle.
      out_push = bus.cpu_out_wr && ((out_cnt_q != OUT_FULL) || out_pop);
      in_push  = bus.dev_in_valid && (in_cnt_q != IN_FULL);
      in_pop   = bus.cpu_in_rd && (in_cnt_q != '0);

      out_wp_d  = out_push ? out_wp_q + OPW'(1) : out_wp_q;
      out_rp_d  = out_pop  ? out_rp_q + OPW'(1) : out_rp_q;
      out_cnt_d = out_cnt_q + OCW'(out_push) - OCW'(out_pop);
      last_d    = out_push ? bus.cpu_out_data : last_q;

      in_wp_d   = in_push ? in_wp_q + IPW'(1) : in_wp_q;
      in_rp_d   = in_pop  ? in_rp_q + IPW'(1) : in_rp_q;
      in_cnt_d  = in_cnt_q + ICW'(in_push) - ICW'(in_pop);

      // New error events win over a coincident clear.
      ovf_d = (bus.cpu_out_wr && !out_push) || (ovf_q && !bus.status_clr);
      unf_d = (bus.cpu_in_rd && (in_cnt_q == '0)) || (unf_q && !bus.status_clr);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_wp_q  <= '0;
         out_rp_q  <= '0;
         out_cnt_q <= '0;
         in_wp_q   <= '0;
         in_rp_q   <= '0;
         in_cnt_q  <= '0;
         last_q    <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         out_wp_q  <= out_wp_d;
         out_rp_q  <= out_rp_d;
         out_cnt_q <= out_cnt_d;
         in_wp_q   <= in_wp_d;
         in_rp_q   <= in_rp_d;
         in_cnt_q  <= in_cnt_d;
         last_q    <= last_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   // Storage is not reset; the counts gate every use of it.
   always_ff @(posedge clk) begin
      if (out_push) out_mem_q[out_wp_q] <= bus.cpu_out_data;
      if (in_push)  in_mem_q[in_wp_q]   <= bus.dev_in_data;
   end

   assign bus.cpu_out_full  = (out_cnt_q == OUT_FULL);
   assign bus.dev_out_valid = (out_cnt_q != '0);
   assign bus.dev_out_data  = out_mem_q[out_rp_q];
   assign bus.cpu_in_empty  = (in_cnt_q == '0);
   assign bus.cpu_in_data   = (in_cnt_q == '0) ? '0 : in_mem_q[in_rp_q];
   assign bus.dev_in_ready  = (in_cnt_q != IN_FULL);
   assign bus.last_out      = last_q;
   assign bus.out_count     = out_cnt_q;
   assign bus.in_count      = in_cnt_q;
   assign bus.overflow      = ovf_q;
   assign bus.underflow     = unf_q;
endmodule

// File: tb/tb_io_port_bridge.sv
module tb_io_port_bridge;
   localparam int BITS = 32;
   localparam int OD   = 4;
   localparam int ID   = 4;

   logic clk;
   logic reset;

   io_port_bridge_if #(.BITS(BITS), .OUT_DEPTH(OD), .IN_DEPTH(ID)) bus ();

   io_port_bridge #(.BITS(BITS), .OUT_DEPTH(OD), .IN_DEPTH(ID)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   // Reference model: plain queues plus sticky bits.
   logic [BITS-1:0] oq[$];
   logic [BITS-1:0] iq[$];
   logic [BITS-1:0] m_last = '0;
   bit              m_ovf  = 1'b0;
   bit              m_unf  = 1'b0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic model_clear();
      oq.delete();
      iq.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   task automatic model_update();
      bit pop_o, acc, push_i, pop_i, unf_evt;
      pop_o   = (oq.size() > 0) && bus.dev_out_ready;
      acc     = bus.cpu_out_wr && ((oq.size() < OD) || pop_o);
      push_i  = bus.dev_in_valid && (iq.size() < ID);
      pop_i   = bus.cpu_in_rd && (iq.size() > 0);
      unf_evt = bus.cpu_in_rd && (iq.size() == 0);
      m_ovf   = (bus.cpu_out_wr && !acc) || (m_ovf && !bus.status_clr);
      m_unf   = unf_evt || (m_unf && !bus.status_clr);
      if (pop_o) void'(oq.pop_front());
      if (acc) begin
         oq.push_back(bus.cpu_out_data);
         m_last = bus.cpu_out_data;
      end
      if (pop_i) void'(iq.pop_front());
      if (push_i) iq.push_back(bus.dev_in_data);
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_update();
      @(negedge clk);
      #1;
   endtask

   // Compare process: every cycle, DUT outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cpu_out_full",  64'(bus.cpu_out_full),  64'(oq.size() == OD));
         chk("dev_out_valid", 64'(bus.dev_out_valid), 64'(oq.size() != 0));
         if (oq.size() != 0)
            chk("dev_out_data", 64'(bus.dev_out_data), 64'(oq[0]));
         chk("cpu_in_empty",  64'(bus.cpu_in_empty),  64'(iq.size() == 0));
         chk("cpu_in_data",   64'(bus.cpu_in_data),   (iq.size() != 0) ? 64'(iq[0]) : 64'd0);
         chk("dev_in_ready",  64'(bus.dev_in_ready),  64'(iq.size() < ID));
         chk("last_out",      64'(bus.last_out),      64'(m_last));
         chk("out_count",     64'(bus.out_count),     64'(oq.size()));
         chk("in_count",      64'(bus.in_count),      64'(iq.size()));
         chk("overflow",      64'(bus.overflow),      64'(m_ovf));
         chk("underflow",     64'(bus.underflow),     64'(m_unf));
      end
   end

   logic [BITS-1:0] exp_out [4];
   logic [BITS-1:0] exp_in  [4];

   initial begin
      reset             = 1'b0;
      bus.cpu_out_wr    = 1'b0;
      bus.cpu_out_data  = '0;
      bus.cpu_in_rd     = 1'b0;
      bus.dev_out_ready = 1'b0;
      bus.dev_in_valid  = 1'b0;
      bus.dev_in_data   = '0;
      bus.status_clr    = 1'b0;
      model_clear();
      step();
      step();
      chk_en = 1'b1;
      reset  = 1'b1;
      step();

      // Idle after reset
      chk("rst_in_empty",  64'(bus.cpu_in_empty), 64'd1);
      chk("rst_in_data",   64'(bus.cpu_in_data), 64'd0);
      chk("rst_in_ready",  64'(bus.dev_in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.dev_out_valid), 64'd0);
      chk("rst_out_count", 64'(bus.out_count), 64'd0);
      chk("rst_in_count",  64'(bus.in_count), 64'd0);

      // Single word, 1-cycle latency
      bus.cpu_out_wr = 1'b1; bus.cpu_out_data = 32'h0000_00A5;
      step();
      bus.cpu_out_wr = 1'b0;
      chk("a5_valid",     64'(bus.dev_out_valid), 64'd1);
      chk("a5_data",      64'(bus.dev_out_data), 64'hA5);
      chk("a5_last",      64'(bus.last_out), 64'hA5);
      chk("a5_count",     64'(bus.out_count), 64'd1);
      chk("a5_model_head", 64'(oq[0]), 64'hA5);
      bus.dev_out_ready = 1'b1;
      step();
      bus.dev_out_ready = 1'b0;
      chk("a5_drained", 64'(bus.dev_out_valid), 64'd0);

      // Overflow: 5 writes into a depth-4 FIFO
      for (int i = 1; i <= 5; i++) begin
         bus.cpu_out_wr = 1'b1; bus.cpu_out_data = 32'(i);
         step();
         if (i == 4) chk("full_after_4", 64'(bus.cpu_out_full), 64'd1);
      end
      bus.cpu_out_wr = 1'b0;
      chk("ovf_set",   64'(bus.overflow), 64'd1);
      chk("ovf_last",  64'(bus.last_out), 64'h4);
      chk("ovf_count", 64'(bus.out_count), 64'd4);
      chk("ovf_head",  64'(bus.dev_out_data), 64'h1);
      chk("ovf_model_size", 64'(oq.size()), 64'd4);
      bus.status_clr = 1'b1;
      step();
      bus.status_clr = 1'b0;
      chk("ovf_cleared", 64'(bus.overflow), 64'd0);

      // Full with simultaneous push and pop
      bus.cpu_out_wr = 1'b1; bus.cpu_out_data = 32'h9; bus.dev_out_ready = 1'b1;
      step();
      bus.cpu_out_wr = 1'b0; bus.dev_out_ready = 1'b0;
      chk("pp_count", 64'(bus.out_count), 64'd4);
      chk("pp_head",  64'(bus.dev_out_data), 64'h2);
      chk("pp_ovf",   64'(bus.overflow), 64'd0);
      chk("pp_last",  64'(bus.last_out), 64'h9);
      exp_out = '{32'h2, 32'h3, 32'h4, 32'h9};
      bus.dev_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", 64'(bus.dev_out_data), 64'(exp_out[i]));
         step();
      end
      bus.dev_out_ready = 1'b0;
      chk("drain_empty", 64'(bus.dev_out_valid), 64'd0);

      // Asynchronous reset mid-burst
      for (int i = 0; i < 3; i++) begin
         bus.cpu_out_wr = 1'b1; bus.cpu_out_data = 32'h100 + 32'(i);
         step();
      end
      bus.cpu_out_wr = 1'b0;
      chk("pre_rst_count", 64'(bus.out_count), 64'd3);
      reset = 1'b0;
      model_clear();
      #1;
      chk("async_rst_count", 64'(bus.out_count), 64'd0);
      chk("async_rst_valid", 64'(bus.dev_out_valid), 64'd0);
      chk("async_rst_last",  64'(bus.last_out), 64'd0);
      step();
      reset = 1'b1;
      step();

      // Input FIFO fill with back-pressure
      bus.dev_in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         bus.dev_in_data = 32'(i * 16);
         step();
      end
      bus.dev_in_data = 32'h50;
      step();
      chk("in_full_ready", 64'(bus.dev_in_ready), 64'd0);
      chk("in_full_count", 64'(bus.in_count), 64'd4);
      chk("in_head_10",    64'(bus.cpu_in_data), 64'h10);
      bus.cpu_in_rd = 1'b1;
      step();
      bus.cpu_in_rd = 1'b0;
      chk("in_pop_head",  64'(bus.cpu_in_data), 64'h20);
      chk("in_pop_ready", 64'(bus.dev_in_ready), 64'd1);
      chk("in_pop_count", 64'(bus.in_count), 64'd3);
      step();
      bus.dev_in_valid = 1'b0;
      chk("in_50_accepted", 64'(bus.in_count), 64'd4);
      exp_in = '{32'h20, 32'h30, 32'h40, 32'h50};
      bus.cpu_in_rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("in_read_order", 64'(bus.cpu_in_data), 64'(exp_in[i]));
         step();
      end
      bus.cpu_in_rd = 1'b0;
      chk("in_drained", 64'(bus.cpu_in_empty), 64'd1);
      chk("in_drained_unf", 64'(bus.underflow), 64'd0);

      // Underflow and set-wins-over-clear
      bus.cpu_in_rd = 1'b1;
      step();
      chk("unf_set",   64'(bus.underflow), 64'd1);
      chk("unf_data",  64'(bus.cpu_in_data), 64'd0);
      chk("unf_count", 64'(bus.in_count), 64'd0);
      bus.status_clr = 1'b1;
      step();
      chk("unf_set_wins", 64'(bus.underflow), 64'd1);
      bus.cpu_in_rd = 1'b0;
      step();
      bus.status_clr = 1'b0;
      chk("unf_cleared", 64'(bus.underflow), 64'd0);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         bus.cpu_out_wr    = ($urandom_range(0, 2) != 0);
         bus.cpu_out_data  = $urandom;
         bus.dev_out_ready = ($urandom_range(0, 2) == 0);
         bus.dev_in_valid  = ($urandom_range(0, 2) != 0);
         bus.dev_in_data   = $urandom;
         bus.cpu_in_rd     = ($urandom_range(0, 2) == 0);
         bus.status_clr    = ($urandom_range(0, 15) == 0);
         step();
      end
      bus.cpu_out_wr = 1'b0; bus.cpu_in_rd = 1'b0; bus.dev_in_valid = 1'b0;
      bus.dev_out_ready = 1'b0; bus.status_clr = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- Device-side end of the processor's INPUT/OUTPUT port interface.
- Buffers words the datapath writes through its OUTPUT port (OUTPUTin strobe) into a FIFO and drains them to an external device over a valid/ready handshake.
- Accepts words from an external device into a second FIFO and presents the head word to the datapath's INPUTUnit, popping it when the datapath asserts INPUTout.

Parameters:
- BITS, 32, data word width.
- OUT_DEPTH, 4, output FIFO entries (power of two, >=2).
- IN_DEPTH, 4, input FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- cpu_out_wr  in  1  one-cycle write strobe (the datapath's OUTPUTin).
- cpu_out_data  in  BITS  word written (the datapath's OUTPUTUnit/bus value).
- cpu_out_full  out  1  output FIFO full.
- cpu_in_rd  in  1  one-cycle read/pop strobe (the datapath's INPUTout).
- cpu_in_data  out  BITS  head of input FIFO (drives INPUTUnit); 0 when empty.
- cpu_in_empty  out  1  input FIFO empty.
- dev_out_valid  out  1  output FIFO non-empty.
- dev_out_data  out  BITS  output FIFO head word.
- dev_out_ready  in  1  device accepts head word.
- dev_in_valid  in  1  device presents a word.
- dev_in_data  in  BITS  device word.
- dev_in_ready  out  1  input FIFO not full.
- last_out  out  BITS  last word accepted from cpu_out_wr.
- out_count  out  clog2(OUT_DEPTH)+1  output FIFO occupancy.
- in_count  out  clog2(IN_DEPTH)+1  input FIFO occupancy.
- overflow  out  1  sticky: cpu_out_wr dropped.
- underflow  out  1  sticky: cpu_in_rd while empty.
- status_clr  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (reset=0, asynchronous): pointers and counts 0, last_out=0, overflow=underflow=0. Thus cpu_out_full=0, cpu_in_empty=1, cpu_in_data=0, dev_out_valid=0, dev_in_ready=1. FIFO storage is not required to be cleared. Reset mid-transfer discards all buffered words.
- Both FIFOs are show-ahead. Heads (dev_out_data, cpu_in_data) are combinational from storage at the read pointer. Status outputs derive combinationally from registered counts.
- Output FIFO push: on cpu_out_wr. Accepted if count<OUT_DEPTH, or if count==OUT_DEPTH and a pop (dev_out_valid & dev_out_ready) occurs in the same cycle. An accepted push writes storage, advances the write pointer and loads last_out next edge.
- Output FIFO drop: when full with no pop, the word is dropped, overflow set, last_out unchanged.
- Output FIFO pop: on dev_out_valid & dev_out_ready. Simultaneous push+pop leaves count unchanged. Push into an empty FIFO is visible on dev_out_valid the next cycle (1-cycle latency).
- Input FIFO push: on dev_in_valid & dev_in_ready. dev_in_ready=0 when full; the device must hold the word. Simultaneous device push and cpu pop when full is not accepted, because ready is low.
- Input FIFO pop: on cpu_in_rd while non-empty. cpu_in_data shows the next word (or 0) after the edge. cpu_in_rd while empty sets underflow and changes nothing else. A push into an empty FIFO appears on cpu_in_data the next cycle; a same-cycle cpu_in_rd is an underflow.
- Pointers wrap modulo depth; counts range 0..DEPTH inclusive.
- Sticky flags: status_clr clears both flags. If status_clr coincides with a new error event, the flag ends set (set wins).
- cpu_out_wr/cpu_in_rd held high multiple cycles: one operation per cycle.

Test Plan:
- Reset then idle: cpu_in_empty=1, cpu_in_data=0, dev_in_ready=1, dev_out_valid=0, counts 0. Assert reset low mid-burst after 3 pushes -> out_count=0 immediately.
- cpu_out_wr with 0x0000_00A5, dev_out_ready=0 -> next cycle dev_out_valid=1, dev_out_data=0xA5, last_out=0xA5, out_count=1. Raise dev_out_ready -> valid drops the cycle after.
- Write 5 words 0x1..0x5 with dev_out_ready=0 -> cpu_out_full after 4th, 0x5 dropped, overflow=1, last_out=0x4. Drain order 1,2,3,4. status_clr -> overflow=0.
- Full output FIFO with simultaneous cpu_out_wr(0x9) and dev_out_ready=1 -> 0x1 popped, 0x9 accepted, out_count stays 4, overflow stays 0.
- Device pushes 0x10,0x20,0x30,0x40,0x50 back-to-back -> dev_in_ready=0 after 4th, 0x50 held. cpu_in_rd pops 0x10 -> 0x50 accepted next cycle. Reads return 0x20,0x30,0x40,0x50 in order.
- cpu_in_rd on empty FIFO -> underflow=1, cpu_in_data=0, in_count=0. Simultaneous status_clr with another empty read -> underflow remains 1.
